// File: rtl/axi_mem_responder.sv
// AXI4 memory-mapped responder: independent read (AR/R) and write (AW/W/B) FSMs sharing one word RAM.
// Define AXI_MEM_BACKPRESSURE_EN to add LFSR-driven ready gating and random R-beat stalls.
module axi_mem_responder #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          MEM_DEPTH  = 4096,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arcache,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awcache,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    step = ADDR_WIDTH'(1) << size;
    if (burst == 2'b01) return (addr & ~(step - ADDR_WIDTH'(1))) + step;
    return addr;
  endfunction

  // Attribute errors take precedence per beat; range errors only apply to legal bursts.
  function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
    if (burst[1] || (size > 3'(BYTE_SHIFT))) return RESP_SLVERR;
    if ((addr >> BYTE_SHIFT) >= DEPTH_LIMIT) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_WIDTH'(addr >> BYTE_SHIFT);
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic ar_gate, aw_gate, w_gate, r_present;
  logic unused_attrs;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) lfsr <= LFSR_SEED;
    else           lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign ar_gate      = lfsr[0];
  assign aw_gate      = lfsr[0];
  assign w_gate       = lfsr[0];
  assign r_present    = lfsr[1];
  assign unused_attrs = ^{arprot, arcache, awprot, awcache};
`else
  assign ar_gate      = 1'b1;
  assign aw_gate      = 1'b1;
  assign w_gate       = 1'b1;
  assign r_present    = 1'b1;
  assign unused_attrs = ^{arprot, arcache, awprot, awcache, LFSR_SEED};
`endif

  // ---------------- read side ----------------
  r_state_t              r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_n;
  logic [7:0]            r_len, r_len_n, r_cnt, r_cnt_n;
  logic [2:0]            r_size, r_size_n;
  logic [1:0]            r_burst, r_burst_n;
  logic                  arready_q, arready_n, rvalid_q, rvalid_n;
  logic                  rlast_q, rlast_n, r_pend, r_pend_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0]            rresp_q, rresp_n;
  logic                  fetch;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [2:0]            fetch_size;
  logic [1:0]            fetch_burst, fetch_resp;

  assign arready = arready_q & ar_gate;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  always_comb begin
    r_state_n   = r_state;
    r_addr_n    = r_addr;
    r_len_n     = r_len;
    r_cnt_n     = r_cnt;
    r_size_n    = r_size;
    r_burst_n   = r_burst;
    arready_n   = arready_q;
    rvalid_n    = rvalid_q;
    rlast_n     = rlast_q;
    r_pend_n    = r_pend;
    rdata_n     = rdata_q;
    rresp_n     = rresp_q;
    fetch       = 1'b0;
    fetch_addr  = r_addr;
    fetch_size  = r_size;
    fetch_burst = r_burst;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          arready_n   = 1'b0;
          fetch       = 1'b1;
          fetch_addr  = araddr;
          fetch_size  = arsize;
          fetch_burst = arburst;
          r_addr_n    = araddr;
          r_len_n     = arlen;
          r_size_n    = arsize;
          r_burst_n   = arburst;
          r_cnt_n     = 8'd0;
          rlast_n     = (arlen == 8'd0);
          rvalid_n    = r_present;
          r_pend_n    = ~r_present;
          r_state_n   = R_DATA;
        end
      end
      R_DATA: begin
        if (r_pend) begin
          rvalid_n = 1'b1;
          r_pend_n = 1'b0;
        end else if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            arready_n = 1'b1;
            r_state_n = R_IDLE;
          end else begin
            fetch      = 1'b1;
            fetch_addr = next_addr(r_addr, r_size, r_burst);
            r_addr_n   = fetch_addr;
            r_cnt_n    = r_cnt + 8'd1;
            rlast_n    = ((r_cnt + 8'd1) == r_len);
            rvalid_n   = r_present;
            r_pend_n   = ~r_present;
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    // Asynchronous array read sampled at the edge gives read-before-write on collisions.
    fetch_resp = beat_resp(fetch_addr, fetch_size, fetch_burst);
    if (fetch) begin
      rresp_n = fetch_resp;
      rdata_n = (fetch_resp == RESP_OKAY) ? mem[word_idx(fetch_addr)] : '0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_pend    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state   <= r_state_n;
      r_addr    <= r_addr_n;
      r_len     <= r_len_n;
      r_cnt     <= r_cnt_n;
      r_size    <= r_size_n;
      r_burst   <= r_burst_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rlast_q   <= rlast_n;
      r_pend    <= r_pend_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  // ---------------- write side ----------------
  w_state_t              w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_n;
  logic [7:0]            w_len, w_len_n, w_cnt, w_cnt_n;
  logic [2:0]            w_size, w_size_n;
  logic [1:0]            w_burst, w_burst_n;
  logic [1:0]            w_acc, w_acc_n, bresp_q, bresp_n, w_beat_resp;
  logic                  awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
  logic                  mem_we, last_by_cnt;

  assign awready = awready_q & aw_gate;
  assign wready  = wready_q & w_gate;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always_comb begin
    w_state_n   = w_state;
    w_addr_n    = w_addr;
    w_len_n     = w_len;
    w_cnt_n     = w_cnt;
    w_size_n    = w_size;
    w_burst_n   = w_burst;
    w_acc_n     = w_acc;
    bresp_n     = bresp_q;
    awready_n   = awready_q;
    wready_n    = wready_q;
    bvalid_n    = bvalid_q;
    mem_we      = 1'b0;
    w_beat_resp = beat_resp(w_addr, w_size, w_burst);
    last_by_cnt = (w_cnt == w_len);
    case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        if (awvalid && awready) begin
          awready_n = 1'b0;
          wready_n  = 1'b1;
          w_addr_n  = awaddr;
          w_len_n   = awlen;
          w_size_n  = awsize;
          w_burst_n = awburst;
          w_cnt_n   = 8'd0;
          w_acc_n   = RESP_OKAY;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          mem_we  = (w_beat_resp == RESP_OKAY);
          w_acc_n = worst(w_acc, w_beat_resp);
          if (wlast != last_by_cnt) w_acc_n = worst(w_acc_n, RESP_SLVERR);
          // An early wlast or the final counted beat closes the burst, whichever is first.
          if (wlast || last_by_cnt) begin
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = w_acc_n;
            w_state_n = W_RESP;
          end else begin
            w_cnt_n  = w_cnt + 8'd1;
            w_addr_n = next_addr(w_addr, w_size, w_burst);
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      w_state   <= W_IDLE;
      w_addr    <= '0;
      w_len     <= 8'd0;
      w_cnt     <= 8'd0;
      w_size    <= 3'd0;
      w_burst   <= 2'b00;
      w_acc     <= 2'b00;
      bresp_q   <= 2'b00;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state   <= w_state_n;
      w_addr    <= w_addr_n;
      w_len     <= w_len_n;
      w_cnt     <= w_cnt_n;
      w_size    <= w_size_n;
      w_burst   <= w_burst_n;
      w_acc     <= w_acc_n;
      bresp_q   <= bresp_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
    end
  end

  // RAM has no reset so its contents survive axi_reset.
  always_ff @(posedge axi_aclk) begin
    if (mem_we && !axi_reset) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: a word model plus R/B scoreboards.
module tb_axi_mem_responder;

  logic        axi_aclk = 1'b0;
  logic        axi_reset;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] model [int];
  int          errors = 0;
  int          checks = 0;

  always #5 axi_aclk = ~axi_aclk;

  axi_mem_responder dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arprot(arprot), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awprot(awprot), .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (burst == 2'b10 || burst == 2'b11 || size > 3'd2) return 2'b10;
    if (a[31:2] >= 30'd4096) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
    if (burst != 2'b01) return a;
    return ((a >> size) + 32'd1) << size;
  endfunction

  function automatic logic [1:0] model_worst(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == 2'b10 || b == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  task automatic push_read_expect(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    rbeat_t      e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.resp = model_resp(a, size, burst);
      e.data = (e.resp == 2'b00) ? model[int'(a[31:2])] : 32'h0;
      e.last = (i == int'(len));
      exp_r.push_back(e);
      a = model_next(a, size, burst);
    end
  endtask

  task automatic issue_ar(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin @(posedge axi_aclk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL %s ar_timeout: arready=%b required 1", tag, arready);
    end
    @(posedge axi_aclk); #1;
    arvalid = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready toggles 1,0,1,0,...
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    int cyc;
    push_read_expect(addr, len, size, burst);
    issue_ar(tag, addr, len, size, burst);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s r_latency: rvalid=%b required 1", tag, rvalid);
    end
    cyc = 0;
    while (exp_r.size() > 0 && cyc < 200) begin
      rready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (mode == 0) begin
        checks++;
        if (rvalid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s r_bubble: rvalid=%b required 1", tag, rvalid);
        end
      end
      if (rvalid === 1'b1) begin
        checks++;
        if (rdata !== exp_r[0].data || rresp !== exp_r[0].resp || rlast !== exp_r[0].last) begin
          errors++;
          $display("[TB] FAIL %s r_beat: got data=%h resp=%b last=%b required data=%h resp=%b last=%b",
                   tag, rdata, rresp, rlast, exp_r[0].data, exp_r[0].resp, exp_r[0].last);
        end
        if (rready) void'(exp_r.pop_front());
      end
      @(posedge axi_aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (exp_r.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s r_timeout: %0d beats outstanding required 0", tag, exp_r.size());
      exp_r.delete();
    end else if (rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s r_end: rvalid=%b required 0", tag, rvalid);
    end
  endtask

  // Beat data/strobes come from wd_q/ws_q; wlast_beat = -1 never asserts wlast.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_beat);
    logic [31:0] a, w;
    logic [1:0]  r, acc;
    int          nbeats, n, idx;
    logic        lc, wl;
    a = addr; acc = 2'b00; nbeats = 0;
    for (int i = 0; i < 256; i++) begin
      lc = (i == int'(len));
      wl = (i == wlast_beat);
      r  = model_resp(a, size, burst);
      if (r == 2'b00) begin
        idx = int'(a[31:2]);
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (ws_q[i][b]) w[b*8 +: 8] = wd_q[i][b*8 +: 8];
        model[idx] = w;
      end
      acc = model_worst(acc, r);
      if (wl != lc) acc = model_worst(acc, 2'b10);
      nbeats = i + 1;
      if (wl || lc) break;
      a = model_next(a, size, burst);
    end
    exp_b.push_back(acc);

    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(posedge axi_aclk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL %s aw_timeout: awready=%b required 1", tag, awready);
    end
    @(posedge axi_aclk); #1;
    awvalid = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wd_q[i]; wstrb = ws_q[i]; wlast = (i == wlast_beat);
      n = 0;
      while (wready !== 1'b1 && n < 100) begin @(posedge axi_aclk); #1; n++; end
      if (n >= 100) begin
        checks++; errors++;
        $display("[TB] FAIL %s w_timeout: wready=%b required 1", tag, wready);
      end
      @(posedge axi_aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    wd_q.delete(); ws_q.delete();

    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(posedge axi_aclk); #1; n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL %s b_timeout: bvalid=%b required 1", tag, bvalid);
      exp_b.delete();
    end else begin
      if (bresp !== exp_b[0]) begin
        errors++;
        $display("[TB] FAIL %s bresp: got %b required %b", tag, bresp, exp_b[0]);
      end
      void'(exp_b.pop_front());
      @(posedge axi_aclk); #1;
    end
    bready = 1'b0;
  endtask

  task automatic test_reset();
    axi_reset = 1'b1;
    repeat (3) @(posedge axi_aclk);
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0 ||
        rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ar=%b aw=%b w=%b rv=%b rl=%b bv=%b rdata=%h rresp=%b bresp=%b required all 0",
               arready, awready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp);
    end
    axi_reset = 1'b0;
    @(posedge axi_aclk); #1;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: arready=%b awready=%b wready=%b required 1 1 0",
               arready, awready, wready);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA0 + i); ws_q.push_back(4'hF); end
    do_write("preload_100", 32'h100, 8'd3, 3'd2, 2'b01, 3);
    wd_q.push_back(32'h0000_4444); ws_q.push_back(4'hF);
    do_write("preload_10", 32'h10, 8'd0, 3'd2, 2'b01, 0);
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);
    do_write("preload_200", 32'h200, 8'd1, 3'd2, 2'b01, 1);
    wd_q.push_back(32'h3FFC_5A5A); ws_q.push_back(4'hF);
    do_write("preload_3ffc", 32'h3FFC, 8'd0, 3'd2, 2'b01, 0);
    for (int i = 0; i < 8; i++) begin wd_q.push_back(32'hC0DE_0000 + (i * 32'h111)); ws_q.push_back(4'hF); end
    do_write("preload_400", 32'h400, 8'd7, 3'd2, 2'b01, 7);
  endtask

  task automatic test_incr_read();
    do_read("incr_read", 32'h100, 8'd3, 3'd2, 2'b01, 0);
  endtask

  task automatic test_strobe_write();
    wd_q.push_back(32'h1122_3344); ws_q.push_back(4'hF);
    wd_q.push_back(32'hAABB_CCDD); ws_q.push_back(4'b0101);
    do_write("strobe_write", 32'h200, 8'd1, 3'd2, 2'b01, 1);
    do_read("strobe_readback", 32'h200, 8'd1, 3'd2, 2'b01, 0);
  endtask

  task automatic test_fixed_read();
    do_read("fixed_read", 32'h10, 8'd2, 3'd2, 2'b00, 1);
  endtask

  task automatic test_errors();
    do_read("decerr_read", 32'h3FFC, 8'd1, 3'd2, 2'b01, 0);
    do_read("badsize_read", 32'h100, 8'd1, 3'd3, 2'b01, 0);
    wd_q.push_back(32'h0BAD_0BAD); ws_q.push_back(4'hF);
    do_write("wrap_write", 32'h200, 8'd0, 3'd2, 2'b10, 0);
    do_read("wrap_readback", 32'h200, 8'd0, 3'd2, 2'b01, 0);
    wd_q.push_back(32'h1234_5678); ws_q.push_back(4'hF);
    do_write("decerr_write", 32'h4000, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_early_wlast();
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'h5000_0000 + i); ws_q.push_back(4'hF); end
    do_write("early_wlast", 32'h300, 8'd3, 3'd2, 2'b01, 1);
    wd_q.push_back(32'h7777_0000); ws_q.push_back(4'hF);
    wd_q.push_back(32'h7777_0001); ws_q.push_back(4'hF);
    do_write("missing_wlast", 32'h308, 8'd1, 3'd2, 2'b01, -1);
    wd_q.push_back(32'h6666_6666); ws_q.push_back(4'hF);
    do_write("after_early", 32'h310, 8'd0, 3'd2, 2'b01, 0);
    do_read("early_readback", 32'h300, 8'd4, 3'd2, 2'b01, 0);
  endtask

  task automatic test_back_to_back();
    do_read("b2b_first", 32'h400, 8'd1, 3'd2, 2'b01, 0);
    do_read("b2b_second", 32'h408, 8'd1, 3'd2, 2'b01, 0);
  endtask

  task automatic test_reset_mid_read();
    int got, cyc;
    push_read_expect(32'h400, 8'd7, 3'd2, 2'b01);
    issue_ar("mid_reset", 32'h400, 8'd7, 3'd2, 2'b01);
    rready = 1'b1;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      if (rvalid === 1'b1) begin
        checks++;
        if (rdata !== exp_r[0].data || rresp !== exp_r[0].resp) begin
          errors++;
          $display("[TB] FAIL mid_reset r_beat: got data=%h resp=%b required data=%h resp=%b",
                   rdata, rresp, exp_r[0].data, exp_r[0].resp);
        end
        void'(exp_r.pop_front());
        got++;
      end
      @(posedge axi_aclk); #1;
      cyc++;
    end
    exp_r.delete();
    axi_reset = 1'b1; rready = 1'b0;
    @(posedge axi_aclk); #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: rvalid=%b arready=%b rlast=%b rdata=%h required 0 0 0 0",
               rvalid, arready, rlast, rdata);
    end
    axi_reset = 1'b0;
    @(posedge axi_aclk); #1;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
    end
    do_read("ram_preserved", 32'h400, 8'd7, 3'd2, 2'b01, 0);
  endtask

  initial begin
    axi_reset = 1'b1;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arprot = '0; arcache = '0; arvalid = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awprot = '0; awcache = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    test_reset();
    preload();
    test_incr_read();
    test_strobe_write();
    test_fixed_read();
    test_errors();
    test_early_wlast();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Synthesizable AXI4 memory-mapped slave (responder) that services the DMA's MM2S read bursts (AR/R) and S2MM write bursts (AW/W/B) from an internal word RAM.
- Sits at the far end of the DMA's AXI master ports, in place of the bench memory model, for RTL-level loopback and emulation.
- The read and write sides are independent FSMs sharing one RAM.

Parameters:
- ADDR_WIDTH, 32: width of araddr and awaddr.
- DATA_WIDTH, 32: data width; strobe width is DATA_WIDTH/8.
- MEM_DEPTH, 4096: number of DATA_WIDTH words; word index = addr >> log2(DATA_WIDTH/8).
- LFSR_SEED, 16'hACE1: stall LFSR seed; used only with AXI_MEM_BACKPRESSURE_EN.

Ports:
- axi_aclk in 1: the single clock.
- axi_reset in 1: synchronous, active-high reset.
- araddr in ADDR_WIDTH; arlen in 8; arsize in 3; arburst in 2; arprot in 3 (ignored); arcache in 4 (ignored); arvalid in 1; arready out 1.
- rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
- awaddr in ADDR_WIDTH; awlen in 8; awsize in 3; awburst in 2; awprot in 3 (ignored); awcache in 4 (ignored); awvalid in 1; awready out 1.
- wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
- bresp out 2; bvalid out 1; bready in 1.

Behaviour:
- Reset (axi_reset=1, sampled at the edge):
  - All outputs go to 0: arready, awready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp.
  - Both FSMs go to IDLE; any in-flight burst is abandoned with no response.
  - RAM contents are preserved.
  - arready and awready rise on the first edge with axi_reset=0.
- Read FSM states R_IDLE and R_DATA:
  - R_IDLE: arready=1.
  - AR handshake: latch addr/len/size/burst, clear the beat counter, register rdata from the RAM, drop arready, go to R_DATA. rvalid=1 on the next cycle (1-cycle latency).
  - R_DATA: rvalid held with rdata/rresp/rlast stable until rready.
  - Each handshake on a non-last beat: advance the address, fetch the next word into rdata, present it the following cycle with no bubble.
  - rlast=1 exactly when beat count == len.
  - Last-beat handshake: rvalid=0, return to R_IDLE; arready=1 one cycle later.
- Write FSM states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1.
  - AW handshake: latch the attributes, go to W_DATA with wready=1.
  - Each W handshake writes the bytes whose wstrb bit is set; unstrobed bytes are unchanged.
  - The burst ends on the wlast handshake or on the beat where count == awlen, whichever comes first.
  - At burst end: wready=0, go to W_RESP; bvalid=1 the next cycle, held until bready; then W_IDLE.
- Address rules:
  - FIXED (00): address unchanged.
  - INCR (01): next = (addr & ~(2^size-1)) + 2^size. The first beat may be unaligned; its low address bits are ignored for lane selection.
  - INCR is not bounded at 4 KB; the word index wraps modulo 2^ADDR_WIDTH.
- Responses:
  - WRAP (10) or reserved (11) burst type, or size > log2(DATA_WIDTH/8): SLVERR (10) on every beat; reads return 0, writes are dropped. The beat count is still honoured.
  - Beat word index >= MEM_DEPTH: DECERR (11) for that beat; read data 0, write dropped.
  - wlast mismatch (early, or missing on beat awlen): bresp SLVERR.
  - bresp is the worst of all write beats, priority DECERR > SLVERR > OKAY.
- Simultaneous events:
  - Same-edge write and read fetch of the same word: the read returns the old data (read-before-write).
  - AR and AW in the same cycle: both accepted.
  - wvalid before the AW handshake: ignored (wready=0).

Optional Feature:
- Macro AXI_MEM_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seeded with LFSR_SEED at reset) advances every cycle.
  - arready, awready and wready are additionally gated by lfsr[0]=1.
  - Each R beat presentation is delayed one cycle when lfsr[1]=0.
  - Data and response ordering are unchanged.
- Undefined: no LFSR; the ready/valid timing is exactly as in Behaviour.

Test Plan:
- Write araddr=0x100, arlen=3, INCR, size=2 after preloading words 0x40..0x43 = A0..A3, rready=1 -> rvalid one cycle after AR; beats A0,A1,A2,A3 back-to-back; rlast only on beat 3; rresp=00.
- AW 0x200 len=1 INCR, W beats 0x11223344 with wstrb=F, then 0xAABBCCDD with wstrb=0101 over existing 0xFFFFFFFF -> bresp=00; readback gives 0x11223344 and 0xFFBBFFDD.
- AR FIXED 0x10 len=2 with rready toggled 1,0,1,0,1 -> three beats, all mem[4]; rdata/rlast stable while rready=0.
- AR 0x3FFC len=1 INCR with MEM_DEPTH=4096 -> beat 0 OKAY, beat 1 DECERR with rdata=0. AW with awburst=10 -> bresp=10 and RAM unchanged.
- AW len=3 with wlast on beat 1 -> burst ends after 2 beats, bresp=10, next AW accepted.
- axi_reset pulsed mid-read at beat 2 of 8 -> next cycle rvalid=0 and arready=0; arready=1 after release; RAM preserved.
